result_trace_monitor: RTL and testbench
=======================================

Name: result_trace_monitor

Overview:
Synthesizable successor to the simulation-only result monitor used around the segmented processor. It watches the processor's `result` bus and captures change events (or every cycle, by mode) with a cycle timestamp into a parametrised FWFT FIFO. A valid/ready port drains the FIFO. Width, depth, timestamp width and run timeout are generalised.

Parameters:
DATA_W, 32, width of the watched result bus and of stored data.
DEPTH, 16, FIFO entries; must be a power of 2 and ≥2.
TS_W, 16, timestamp/cycle counter width.
OVF_W, 8, width of the dropped-event counter.
TIMEOUT, 10000, enabled cycles until sticky done; 0 disables the timeout.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
enable  in  1  monitor running; when 0, all counters and capture freeze
mode  in  1  0 = capture on change; 1 = capture every enabled cycle
result  in  DATA_W  watched processor result bus
rd_valid  out  1  FIFO head valid (not empty)
rd_ready  in  1  consumer accepts head
rd_data  out  DATA_W  head entry result value
rd_time  out  TS_W  head entry timestamp
count  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow_cnt  out  OVF_W  events dropped because the FIFO was full; saturates at all-ones
done  out  1  sticky timeout reached

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`. All state updates on the rising edge.
- Reset values: rd_valid=0, count=0, overflow_cnt=0, done=0, cycle counter=0, run counter=0, prev_valid=0. rd_data and rd_time are don't-care while rd_valid=0.
- A reset asserted mid-operation discards all FIFO contents and all counters on that edge.
- Active cycle: enable=1 and done=0.
- Cycle counter (TS_W bits) increments every active cycle and wraps from all-ones to 0.
- Capture condition, evaluated in an active cycle: mode=1, or prev_valid=0, or result≠prev_result.
  - The first active cycle after reset is therefore always captured.
- Captured entry is {result, cycle counter value before the increment}.
- In every active cycle, prev_result←result and prev_valid←1, whether or not the entry was stored. A dropped change does not retrigger on the next cycle.
- Push rules:
  - Capture with count<DEPTH: entry is written.
  - Capture with count=DEPTH and a pop on the same edge: entry is written; count is unchanged.
  - Capture with count=DEPTH and no pop: entry is dropped; overflow_cnt increments, saturating.
- Pop: occurs when rd_valid && rd_ready; rd_valid = (count≠0).
- Pop while empty is impossible. An entry pushed into an empty FIFO raises rd_valid on the following cycle; there is no same-cycle bypass.
- Latency: capture at edge k means rd_valid=1 and rd_data/rd_time show the entry during cycle k+1.
- FWFT: rd_data/rd_time are driven directly from head storage. Head is stable while rd_valid && !rd_ready.
- Occupancy: count increments on push-only, decrements on pop-only, is unchanged on simultaneous push+pop.
- Pointers: log2(DEPTH) bits, naturally wrapping.
- Timeout (TIMEOUT≠0):
  - Run counter increments each active cycle.
  - On the edge where the run counter equals TIMEOUT-1, done←1. That final cycle's capture still happens.
  - done is sticky until reset.
  - With done=1: no captures, and the cycle and run counters freeze. Reads continue, so the FIFO can be drained.
- enable=0: no capture, counters hold, prev_result/prev_valid hold. Reads continue.

Test Plan:
- Change detection: reset, then enable=1, mode=0; drive result=0x0 for 3 cycles, then 0xA5 for 2 cycles, then 0x0. Keep rd_ready=0. Required: count=3, entries (0x0,t0), (0xA5,t3), (0x0,t5).
- Every-cycle mode plus overflow: DEPTH=4, mode=1, rd_ready=0 for 6 enabled cycles. Required: count=4, overflow_cnt=2, stored timestamps 0..3.
- Full with simultaneous push/pop: FIFO full at count=4, mode=1, rd_ready=1 for 3 cycles. Required: count stays 4, overflow_cnt unchanged, popped times are consecutive.
- Backpressure: one entry 0x1234 with rd_ready=0 for 5 cycles. Required: rd_valid=1 and rd_data=0x1234 held stable for 5 cycles, then popped on the first rd_ready=1 edge; count 1→0.
- Timeout: TIMEOUT=8, mode=1, rd_ready=1. Required: done rises after the 8th active edge; exactly 8 entries (times 0..7) delivered; none afterwards.
- Reset mid-run: with count=3, overflow_cnt=1, done=1, assert reset for one cycle. Required: all outputs return to reset values, and the next active cycle captures with timestamp 0.

Source files
------------

// File: rtl/result_trace_monitor.sv
// Watches the result bus and records change events (or every cycle) with a
// cycle timestamp into a first-word-fall-through FIFO drained by valid/ready.
module result_trace_monitor #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int TS_W    = 16,
  parameter int OVF_W   = 8,
  parameter int TIMEOUT = 10000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mode,
  input  logic [DATA_W-1:0]        result,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic [OVF_W-1:0]         overflow_cnt,
  output logic                     done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int RUN_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [DATA_W+TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [TS_W-1:0]        cycle_cnt;
  logic [RUN_W-1:0]       run_cnt;
  logic [DATA_W-1:0]      prev_result;
  logic                   prev_valid;

  logic active;
  logic capture;
  logic pop;
  logic full;
  logic push;
  logic drop;
  logic timeout_hit;

  always_comb begin
    active      = enable && !done;
    capture     = active && (mode || !prev_valid || (result != prev_result));
    rd_valid    = (count != '0);
    pop         = rd_valid && rd_ready;
    full        = (count == CW'(DEPTH));
    push        = capture && (!full || pop);
    drop        = capture && full && !pop;
    timeout_hit = (TIMEOUT != 0) && (run_cnt == RUN_W'(TIMEOUT - 1));
  end

  assign rd_data = mem[rd_ptr][DATA_W+TS_W-1:TS_W];
  assign rd_time = mem[rd_ptr][TS_W-1:0];

  // Storage carries no reset; contents are only visible while rd_valid is set.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {result, cycle_cnt};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
      cycle_cnt    <= '0;
      run_cnt      <= '0;
      done         <= 1'b0;
      prev_result  <= '0;
      prev_valid   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop && (overflow_cnt != '1)) begin
        overflow_cnt <= overflow_cnt + OVF_W'(1);
      end
      if (active) begin
        cycle_cnt   <= cycle_cnt + TS_W'(1);
        run_cnt     <= run_cnt + RUN_W'(1);
        prev_result <= result;
        prev_valid  <= 1'b1;
        if (timeout_hit) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_trace_monitor.sv
// Directed bench: one instance without timeout and one with an 8-cycle timeout,
// both with a 4-entry FIFO, sharing the same stimulus.
module tb_result_trace_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mode;
  logic [31:0] result;
  logic        rd_ready;

  logic        a_rd_valid, t_rd_valid;
  logic [31:0] a_rd_data, t_rd_data;
  logic [15:0] a_rd_time, t_rd_time;
  logic [2:0]  a_count, t_count;
  logic [7:0]  a_ovf, t_ovf;
  logic        a_done, t_done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  result_trace_monitor #(.DATA_W(32), .DEPTH(4), .TS_W(16), .OVF_W(8), .TIMEOUT(0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .result(result),
    .rd_valid(a_rd_valid), .rd_ready(rd_ready), .rd_data(a_rd_data), .rd_time(a_rd_time),
    .count(a_count), .overflow_cnt(a_ovf), .done(a_done)
  );

  result_trace_monitor #(.DATA_W(32), .DEPTH(4), .TS_W(16), .OVF_W(8), .TIMEOUT(8)) dut_t (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .result(result),
    .rd_valid(t_rd_valid), .rd_ready(rd_ready), .rd_data(t_rd_data), .rd_time(t_rd_time),
    .count(t_count), .overflow_cnt(t_ovf), .done(t_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a_valid"}, 64'(a_rd_valid), 64'd0);
    check({tag, "_a_count"}, 64'(a_count), 64'd0);
    check({tag, "_a_ovf"}, 64'(a_ovf), 64'd0);
    check({tag, "_a_done"}, 64'(a_done), 64'd0);
    check({tag, "_t_valid"}, 64'(t_rd_valid), 64'd0);
    check({tag, "_t_count"}, 64'(t_count), 64'd0);
    check({tag, "_t_ovf"}, 64'(t_ovf), 64'd0);
    check({tag, "_t_done"}, 64'(t_done), 64'd0);
  endtask

  initial begin
    int n_deliv;
    logic [15:0] exp_t3 [3];

    reset    = 1'b1;
    enable   = 1'b0;
    mode     = 1'b0;
    result   = 32'h0;
    rd_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_reset_state("reset");

    // Change detection: 0,0,0,A5,A5,0 -> (0,t0) (A5,t3) (0,t5)
    enable = 1'b1;
    mode   = 1'b0;
    result = 32'h0;
    repeat (3) step();
    result = 32'hA5;
    repeat (2) step();
    result = 32'h0;
    step();
    enable = 1'b0;
    check("chg_count", 64'(a_count), 64'd3);
    check("chg_valid", 64'(a_rd_valid), 64'd1);
    check("chg_e0_data", 64'(a_rd_data), 64'h0);
    check("chg_e0_time", 64'(a_rd_time), 64'd0);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    check("chg_e1_data", 64'(a_rd_data), 64'hA5);
    check("chg_e1_time", 64'(a_rd_time), 64'd3);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    check("chg_e2_data", 64'(a_rd_data), 64'h0);
    check("chg_e2_time", 64'(a_rd_time), 64'd5);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    check("chg_empty_count", 64'(a_count), 64'd0);
    check("chg_empty_valid", 64'(a_rd_valid), 64'd0);

    // Every-cycle mode with overflow: 6 captures into 4 entries
    do_reset();
    check_reset_state("rst2");
    enable = 1'b1;
    mode   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      result = 32'(i + 100);
      step();
    end
    enable = 1'b0;
    check("ovf_count", 64'(a_count), 64'd4);
    check("ovf_ovf", 64'(a_ovf), 64'd2);
    check("ovf_head_time", 64'(a_rd_time), 64'd0);
    check("ovf_head_data", 64'(a_rd_data), 64'd100);

    // Full FIFO with simultaneous push and pop; cycle counter is at 6
    enable   = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      result = 32'(i + 200);
      step();
      check($sformatf("full_pp_count_%0d", i), 64'(a_count), 64'd4);
      check($sformatf("full_pp_ovf_%0d", i), 64'(a_ovf), 64'd2);
      check($sformatf("full_pp_head_%0d", i), 64'(a_rd_time), 64'(i + 1));
    end
    enable = 1'b0;
    exp_t3[0] = 16'd6;
    exp_t3[1] = 16'd7;
    exp_t3[2] = 16'd8;
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full_drain_time_%0d", i), 64'(a_rd_time), 64'(exp_t3[i]));
      check($sformatf("full_drain_data_%0d", i), 64'(a_rd_data), 64'(200 + i));
      step();
    end
    rd_ready = 1'b0;
    check("full_drain_count", 64'(a_count), 64'd0);

    // Backpressure: single entry held for 5 cycles, popped on first ready
    do_reset();
    enable = 1'b1;
    mode   = 1'b0;
    result = 32'h1234;
    step();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i), 64'(a_rd_valid), 64'd1);
      check($sformatf("bp_data_%0d", i), 64'(a_rd_data), 64'h1234);
      check($sformatf("bp_count_%0d", i), 64'(a_count), 64'd1);
      step();
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("bp_pop_count", 64'(a_count), 64'd0);
    check("bp_pop_valid", 64'(a_rd_valid), 64'd0);

    // Timeout of 8 active cycles on dut_t
    do_reset();
    enable   = 1'b1;
    mode     = 1'b1;
    rd_ready = 1'b1;
    n_deliv  = 0;
    for (int i = 1; i <= 14; i++) begin
      if (t_rd_valid) begin
        check($sformatf("to_time_%0d", n_deliv), 64'(t_rd_time), 64'(n_deliv));
        n_deliv++;
      end
      result = 32'(i * 3);
      step();
      check($sformatf("to_done_edge_%0d", i), 64'(t_done), 64'(i >= 8));
    end
    check("to_delivered", 64'(n_deliv), 64'd8);
    check("to_final_count", 64'(t_count), 64'd0);
    check("to_final_valid", 64'(t_rd_valid), 64'd0);
    check("to_a_no_done", 64'(a_done), 64'd0);

    // Reach count=3, overflow=1, done=1 on dut_t, then reset mid-run
    do_reset();
    enable   = 1'b1;
    mode     = 1'b1;
    rd_ready = 1'b0;
    repeat (5) step();
    enable   = 1'b0;
    rd_ready = 1'b1;
    step();
    enable = 1'b1;
    repeat (3) step();
    enable   = 1'b0;
    rd_ready = 1'b0;
    check("pre_rst_count", 64'(t_count), 64'd3);
    check("pre_rst_ovf", 64'(t_ovf), 64'd1);
    check("pre_rst_done", 64'(t_done), 64'd1);
    do_reset();
    check_reset_state("midrst");
    enable = 1'b1;
    mode   = 1'b0;
    result = 32'h55;
    step();
    enable = 1'b0;
    check("post_rst_valid", 64'(t_rd_valid), 64'd1);
    check("post_rst_time", 64'(t_rd_time), 64'd0);
    check("post_rst_data", 64'(t_rd_data), 64'h55);
    check("post_rst_count", 64'(t_count), 64'd1);
    check("post_rst_done", 64'(t_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
